// File: rtl/vpi_chk_bank.sv
// Multi-channel sig/rfr checker with scan FSM and free-running stride counter.
// Optional sticky failure flag enabled by defining VPI_CHK_STICKY_EN.
module vpi_chk_bank #(
  parameter int unsigned CHANNELS     = 6,
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CHAN_W       = 3,
  parameter bit          RAMP_WIDTH   = 1'b1,
  parameter logic [31:0] FINISH_COUNT = 32'd1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [CHAN_W-1:0] wr_chan,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              chk_req,
  input  logic              chk_all,
  input  logic [CHAN_W-1:0] chk_chan,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CHAN_W:0]   fail_cnt,
  output logic [CHAN_W-1:0] fail_chan,
  output logic [31:0]       count,
  output logic [31:0]       half_count,
  output logic              finish,
  output logic              sticky_fail
);

  localparam int unsigned CNT_W = CHAN_W + 1;
  localparam logic [CHAN_W-1:0] LAST_IDX = CHAN_W'(CHANNELS - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_REPORT} state_t;

  state_t            r_state;
  logic [CHAN_W-1:0] r_idx;
  logic              r_all;
  logic [WIDTH-1:0]  r_sig [CHANNELS];
  logic [WIDTH-1:0]  r_rfr [CHANNELS];
  logic              w_mismatch;
  logic [31:0]       w_count_nxt;

  // Effective-width mask for channel c: low min(c+1, WIDTH) bits when ramping.
  function automatic logic [WIDTH-1:0] chan_mask(input int unsigned c);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int unsigned b = 0; b < WIDTH; b++) begin
      if (!RAMP_WIDTH || b <= c) m[b] = 1'b1;
    end
    return m;
  endfunction

  // Register file; data is stored pre-masked so upper bits always read 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        r_sig[c] <= '0;
        r_rfr[c] <= '0;
      end
    end else if (wr_en) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        if (wr_chan == CHAN_W'(c)) begin
          if (wr_sel) r_rfr[c] <= wr_data & chan_mask(c);
          else        r_sig[c] <= wr_data & chan_mask(c);
        end
      end
    end
  end

  // An index with no backing channel always counts as a mismatch.
  always_comb begin
    w_mismatch = 1'b1;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (r_idx == CHAN_W'(c)) w_mismatch = (r_sig[c] != r_rfr[c]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_all     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_cnt  <= '0;
      fail_chan <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (chk_req) begin
            fail_cnt  <= '0;
            fail_chan <= '0;
            r_all     <= chk_all;
            r_idx     <= chk_all ? '0 : chk_chan;
            busy      <= 1'b1;
            r_state   <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_mismatch) begin
            fail_cnt <= fail_cnt + CNT_W'(1);
            if (fail_cnt == '0) fail_chan <= r_idx;
          end
          if (!r_all || r_idx == LAST_IDX) r_state <= S_REPORT;
          else                             r_idx   <= r_idx + CHAN_W'(1);
        end
        S_REPORT: begin
          done    <= 1'b1;
          pass    <= (fail_cnt == '0);
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef VPI_CHK_STICKY_EN
  logic r_sticky;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                         r_sticky <= 1'b0;
    else if (r_state == S_REPORT && fail_cnt != '0)  r_sticky <= 1'b1;
  end

  assign sticky_fail = r_sticky;
`else
  assign sticky_fail = 1'b0;
`endif

  assign w_count_nxt = count + 32'd2;

  // Stride counters; finish is registered so it is high while count equals the target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      half_count <= '0;
      finish     <= 1'b0;
    end else begin
      count  <= w_count_nxt;
      finish <= (w_count_nxt == FINISH_COUNT);
      if (count[1]) half_count <= half_count + 32'd2;
    end
  end

endmodule

// File: tb/tb_vpi_chk_bank.sv
// Self-checking bench for vpi_chk_bank: transaction-level model plus directed literal checks.
module tb_vpi_chk_bank;

  localparam int CH = 6;
  localparam int FIN = 1000;

  logic        clk, rst;
  logic        wr_en, wr_sel, chk_req, chk_all;
  logic [2:0]  wr_chan, chk_chan;
  logic [7:0]  wr_data;
  logic        busy, done, pass, finish, sticky_fail;
  logic [3:0]  fail_cnt;
  logic [2:0]  fail_chan;
  logic [31:0] count, half_count;

  vpi_chk_bank dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_chan(wr_chan),
    .wr_data(wr_data), .chk_req(chk_req), .chk_all(chk_all), .chk_chan(chk_chan),
    .busy(busy), .done(done), .pass(pass), .fail_cnt(fail_cnt), .fail_chan(fail_chan),
    .count(count), .half_count(half_count), .finish(finish), .sticky_fail(sticky_fail)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_sig [CH];
  logic [7:0] m_rfr [CH];
  int  m_n, m_start, m_ch, m_ncmp, m_k, m_c;
  bit  m_act;
  int  e_cnt, e_fchan;
  bit  e_pass, e_done, e_busy, e_sticky;

  function automatic logic [7:0] eff_mask(input int c);
    int w;
    w = (c + 1 < 8) ? c + 1 : 8;
    return 8'((1 << w) - 1);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_n = 0; m_act = 0; e_cnt = 0; e_fchan = 0;
      e_pass = 0; e_done = 0; e_busy = 0; e_sticky = 0;
      for (int i = 0; i < CH; i++) begin m_sig[i] = 8'h00; m_rfr[i] = 8'h00; end
    end else begin
      m_n++;
      e_done = 0;
      if (m_act) begin
        // Channel compares land on edges start+1..start+ncmp, result one edge later.
        m_k = m_n - m_start - 1;
        if (m_k < m_ncmp) begin
          m_c = (m_ncmp == CH) ? m_k : m_ch;
          if (m_c >= CH || m_sig[m_c] != m_rfr[m_c]) begin
            if (e_cnt == 0) e_fchan = m_c;
            e_cnt++;
          end
        end else begin
          e_done = 1;
          e_pass = (e_cnt == 0);
`ifdef VPI_CHK_STICKY_EN
          if (!e_pass) e_sticky = 1'b1;
`endif
          m_act = 0;
        end
      end else if (chk_req) begin
        m_act = 1; m_start = m_n; m_ch = int'(chk_chan);
        m_ncmp = chk_all ? CH : 1;
        e_cnt = 0; e_fchan = 0;
      end
      e_busy = m_act;
      if (wr_en && int'(wr_chan) < CH) begin
        if (wr_sel) m_rfr[wr_chan] = wr_data & eff_mask(int'(wr_chan));
        else        m_sig[wr_chan] = wr_data & eff_mask(int'(wr_chan));
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("busy", 32'(busy), 32'(e_busy));
      check("done", 32'(done), 32'(e_done));
      check("pass", 32'(pass), 32'(e_pass));
      check("fail_cnt", 32'(fail_cnt), 32'(e_cnt));
      check("fail_chan", 32'(fail_chan), 32'(e_fchan));
      check("count", count, 32'(2 * m_n));
      check("half_count", half_count, 32'(2 * (m_n / 2)));
      check("finish", 32'(finish), 32'(2 * m_n == FIN));
      check("sticky", 32'(sticky_fail), 32'(e_sticky));
    end
  end

  // ---------------- stimulus ----------------
  task automatic wr(input bit sel, input logic [2:0] ch, input logic [7:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_chan = ch; wr_data = d;
    @(negedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic run_check(input bit all, input logic [2:0] ch, input bit hold,
                           output int lat, output int ndone, output int nbusy,
                           output bit p, output int cnt, output int fch);
    chk_req = 1'b1; chk_all = all; chk_chan = ch;
    lat = 0; ndone = 0; nbusy = 0; p = 0; cnt = -1; fch = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk); #1;
      if (!hold) chk_req = 1'b0;
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        if (lat == 0) begin lat = i - 1; p = pass; cnt = int'(fail_cnt); fch = int'(fail_chan); end
      end
    end
    chk_req = 1'b0;
  endtask

  task automatic rand_drive();
    wr_en    = 1'($urandom_range(0, 1));
    wr_sel   = 1'($urandom_range(0, 1));
    wr_chan  = 3'($urandom_range(0, 7));
    wr_data  = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'($urandom_range(0, 3));
    chk_req  = ($urandom_range(0, 3) == 0);
    chk_all  = 1'($urandom_range(0, 1));
    chk_chan = 3'($urandom_range(0, 7));
  endtask

  int lat, nd, nb, cnt, fch, nfin;
  bit p;
  logic [31:0] fin_count, fin_half;

  initial begin
    rst = 1'b1; wr_en = 0; wr_sel = 0; wr_chan = 0; wr_data = 0;
    chk_req = 0; chk_all = 0; chk_chan = 0;
    repeat (2) @(negedge clk);
    #1;
    chk_on = 1'b1;
    check("rst_busy", 32'(busy), 0);
    check("rst_pass", 32'(pass), 0);
    check("rst_fail_cnt", 32'(fail_cnt), 0);
    check("rst_count", count, 0);
    check("rst_finish", 32'(finish), 0);
    rst = 1'b0;

    // Scan-all with identical zero contents
    for (int c = 0; c < CH; c++) begin wr(0, 3'(c), 8'h00); wr(1, 3'(c), 8'h00); end
    run_check(1, 0, 0, lat, nd, nb, p, cnt, fch);
    check("all_ok_latency", 32'(lat), 7);
    check("all_ok_ndone", 32'(nd), 1);
    check("all_ok_nbusy", 32'(nb), 7);
    check("all_ok_pass", 32'(p), 1);
    check("all_ok_cnt", 32'(cnt), 0);

    // Ramp masking on channel 2 (3 effective bits)
    wr(0, 3'd2, 8'hFF); wr(1, 3'd2, 8'h07);
    run_check(0, 3'd2, 0, lat, nd, nb, p, cnt, fch);
    check("ramp_latency", 32'(lat), 2);
    check("ramp_pass", 32'(p), 1);
    wr(1, 3'd2, 8'h05);
    run_check(0, 3'd2, 0, lat, nd, nb, p, cnt, fch);
    check("ramp_fail_pass", 32'(p), 0);
    check("ramp_fail_cnt", 32'(cnt), 1);
    check("ramp_fail_chan", 32'(fch), 2);

    // Mismatches on channels 1 and 4
    wr(1, 3'd2, 8'h07); wr(0, 3'd1, 8'h01); wr(1, 3'd4, 8'h10);
    run_check(1, 0, 0, lat, nd, nb, p, cnt, fch);
    check("multi_cnt", 32'(cnt), 2);
    check("multi_chan", 32'(fch), 1);
    check("multi_pass", 32'(p), 0);
    run_check(1, 0, 1, lat, nd, nb, p, cnt, fch);
    check("held_req_ndone", 32'(nd), 1);
    check("held_req_cnt", 32'(cnt), 2);
    idle(12);

    // Out-of-range single check and ignored write
    run_check(0, 3'd7, 0, lat, nd, nb, p, cnt, fch);
    check("oor_latency", 32'(lat), 2);
    check("oor_pass", 32'(p), 0);
    check("oor_cnt", 32'(cnt), 1);
    check("oor_chan", 32'(fch), 7);
    wr(0, 3'd6, 8'hFF); wr(1, 3'd6, 8'hAA);
    run_check(1, 0, 0, lat, nd, nb, p, cnt, fch);
    check("oor_wr_cnt", 32'(cnt), 2);
    check("oor_wr_chan", 32'(fch), 1);

    // Reset during the third scan cycle
    chk_req = 1'b1; chk_all = 1'b1;
    @(negedge clk); #1; chk_req = 1'b0;
    idle(2);
    check("midscan_busy_pre", 32'(busy), 1);
`ifdef VPI_CHK_STICKY_EN
    check("midscan_sticky_pre", 32'(sticky_fail), 1);
`endif
    rst = 1'b1;
    #1;
    check("midscan_busy", 32'(busy), 0);
    check("midscan_done", 32'(done), 0);
    check("midscan_fail_cnt", 32'(fail_cnt), 0);
    check("midscan_count", count, 0);
    check("midscan_sticky", 32'(sticky_fail), 0);
    @(negedge clk); #1;
    rst = 1'b0;

    // Counter run with random traffic
    nfin = 0; fin_count = 0; fin_half = 0;
    for (int i = 1; i <= 501; i++) begin
      rand_drive();
      @(negedge clk); #1;
      if (finish) begin nfin++; fin_count = count; fin_half = half_count; end
    end
    check("finish_pulses", 32'(nfin), 1);
    check("finish_count", fin_count, 32'd1000);
    check("finish_half", fin_half, 32'd500);

    for (int i = 0; i < 1500; i++) begin
      rand_drive();
      @(negedge clk); #1;
    end
    wr_en = 0; chk_req = 0;
    idle(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
